// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - MDU opcode encodings, FSM states and op-class helpers
package mdu_pkg;

  localparam logic [3:0] MDU_NOP = 4'd0;
  localparam logic [3:0] MULT    = 4'd1;
  localparam logic [3:0] MULTU   = 4'd2;
  localparam logic [3:0] DIV     = 4'd3;
  localparam logic [3:0] DIVU    = 4'd4;
  localparam logic [3:0] MFHI    = 4'd5;
  localparam logic [3:0] MFLO    = 4'd6;
  localparam logic [3:0] MTHI    = 4'd7;
  localparam logic [3:0] MTLO    = 4'd8;
  localparam logic [3:0] MADD    = 4'd9;
  localparam logic [3:0] MADDU   = 4'd10;
  localparam logic [3:0] MSUB    = 4'd11;
  localparam logic [3:0] MSUBU   = 4'd12;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  function automatic logic is_multi_cycle(input logic [3:0] op);
    return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op inside {DIV, DIVU};
  endfunction

endpackage

// File: rtl/mdu_pipelined_unit_if.sv
// rtl/mdu_pipelined_unit_if.sv - E-stage to MDU request/result bundle
interface mdu_pipelined_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       mdu_op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mdu_out;

  modport master (output start, mdu_op, src_a, src_b, cancel,
                  input  busy, stall, done, hi, lo, mdu_out);
  modport slave  (input  start, mdu_op, src_a, src_b, cancel,
                  output busy, stall, done, hi, lo, mdu_out);
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational next-{hi,lo} for multiply, divide and accumulate ops
module mdu_arith import mdu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic                   w_mul_signed;
  logic [2*WIDTH-1:0]     w_ea, w_eb, w_prod, w_acc;
  logic                   w_na, w_nb;
  logic [WIDTH-1:0]       w_ma, w_mb, w_dv, w_q, w_r, w_quot, w_rem;

  assign w_mul_signed = i_op inside {MULT, MADD, MSUB};
  assign w_ea   = w_mul_signed ? {{WIDTH{i_a[WIDTH-1]}}, i_a} : {{WIDTH{1'b0}}, i_a};
  assign w_eb   = w_mul_signed ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : {{WIDTH{1'b0}}, i_b};
  assign w_prod = w_ea * w_eb;
  assign w_acc  = {i_hi, i_lo};

  // Magnitude divide then re-sign; most-negative / -1 wraps back to most-negative.
  assign w_na   = (i_op == DIV) & i_a[WIDTH-1];
  assign w_nb   = (i_op == DIV) & i_b[WIDTH-1];
  assign w_ma   = w_na ? ('0 - i_a) : i_a;
  assign w_mb   = w_nb ? ('0 - i_b) : i_b;
  assign w_dv   = (w_mb == '0) ? WIDTH'(1) : w_mb;
  assign w_q    = w_ma / w_dv;
  assign w_r    = w_ma % w_dv;
  assign w_quot = (w_na ^ w_nb) ? ('0 - w_q) : w_q;
  assign w_rem  = w_na ? ('0 - w_r) : w_r;

  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    case (i_op)
      MULT, MULTU: {o_hi, o_lo} = w_prod;
      MADD, MADDU: {o_hi, o_lo} = w_acc + w_prod;
      MSUB, MSUBU: {o_hi, o_lo} = w_acc - w_prod;
      DIV, DIVU: begin
        if (i_b != '0) begin
          o_lo = w_quot;
          o_hi = w_rem;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_pipelined_unit.sv
// rtl/mdu_pipelined_unit.sv - multi-cycle MIPS multiply/divide unit holding HI/LO
module mdu_pipelined_unit import mdu_pkg::*; #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic              clk,
  input logic              reset,
  mdu_pipelined_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo;
  logic             r_done;

  logic             w_busy, w_multi, w_accept;
  logic [CW-1:0]    w_cnt_load;
  logic [WIDTH-1:0] w_next_hi, w_next_lo;

  assign w_busy     = (r_state == S_RUN);
  assign w_multi    = is_multi_cycle(bus.mdu_op);
  assign w_accept   = bus.start & ~bus.cancel & ~w_busy;
  assign w_cnt_load = is_div(bus.mdu_op) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);

  // Evaluated against live hi/lo so accumulate ops see the values present at commit.
  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .o_hi (w_next_hi),
    .o_lo (w_next_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= MDU_NOP;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_multi) begin
              r_state <= S_RUN;
              r_cnt   <= w_cnt_load;
              r_op    <= bus.mdu_op;
              r_a     <= bus.src_a;
              r_b     <= bus.src_b;
            end else if (bus.mdu_op == MTHI) begin
              r_hi <= bus.src_a;
            end else if (bus.mdu_op == MTLO) begin
              r_lo <= bus.src_a;
            end
          end
        end
        default: begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_hi    <= w_next_hi;
            r_lo    <= w_next_lo;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.busy    = w_busy;
  assign bus.stall   = w_busy | (bus.start & w_multi & ~bus.cancel);
  assign bus.done    = r_done;
  assign bus.hi      = r_hi;
  assign bus.lo      = r_lo;
  assign bus.mdu_out = (bus.mdu_op == MFHI) ? r_hi :
                       (bus.mdu_op == MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_mdu_pipelined_unit.sv
// tb/tb_mdu_pipelined_unit.sv - directed self-checking bench for mdu_pipelined_unit
module tb_mdu_pipelined_unit;
  import mdu_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mdu_pipelined_unit_if #(.WIDTH(32)) bus();

  mdu_pipelined_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.mdu_op = op; bus.src_a = a; bus.src_b = b;
    step();
    bus.start = 1'b0; bus.mdu_op = MDU_NOP;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    checks += 5;
    if (bus.hi !== 32'h0)      begin errors++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0)      begin errors++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.stall !== 1'b0)    begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall); end
  endtask

  task automatic test_mult();
    int n;
    bus.start = 1'b1; bus.mdu_op = MULT; bus.src_a = 32'hFFFF_FFFD; bus.src_b = 32'd4;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("FAIL mult_stall_pre got %b want 1", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mdu_op = MDU_NOP;
    wait_busy(n);
    checks += 4;
    if (n != 5)                    begin errors++; $display("FAIL mult_busy_cycles got %0d want 5", n); end
    if (bus.done !== 1'b1)         begin errors++; $display("FAIL mult_done got %b want 1", bus.done); end
    if (bus.hi !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFF4)  begin errors++; $display("FAIL mult_lo got %h want fffffff4", bus.lo); end
    step();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", bus.done); end
  endtask

  task automatic test_multu();
    int n;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_busy(n);
    checks += 3;
    if (n != 5)                    begin errors++; $display("FAIL multu_busy_cycles got %0d want 5", n); end
    if (bus.hi !== 32'hFFFF_FFFE)  begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
    if (bus.lo !== 32'h0000_0001)  begin errors++; $display("FAIL multu_lo got %h want 1", bus.lo); end
  endtask

  task automatic test_div();
    int n;
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_busy(n);
    checks += 4;
    if (n != 10)                   begin errors++; $display("FAIL div_busy_cycles got %0d want 10", n); end
    if (bus.done !== 1'b1)         begin errors++; $display("FAIL div_done got %b want 1", bus.done); end
    if (bus.lo !== 32'hFFFF_FFFD)  begin errors++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
    if (bus.hi !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
    issue(DIVU, 32'd7, 32'd2);
    wait_busy(n);
    checks += 2;
    if (bus.lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want 3", bus.lo); end
    if (bus.hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 1", bus.hi); end
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(n);
    checks += 2;
    if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_minneg_lo got %h want 80000000", bus.lo); end
    if (bus.hi !== 32'h0)         begin errors++; $display("FAIL div_minneg_hi got %h want 0", bus.hi); end
  endtask

  task automatic test_move_and_div0();
    int n;
    bus.start = 1'b1; bus.mdu_op = MTHI; bus.src_a = 32'h1234; bus.src_b = 32'h0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL mthi_stall got %b want 0", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mdu_op = MDU_NOP;
    checks += 3;
    if (bus.hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi got %h want 1234", bus.hi); end
    if (bus.busy !== 1'b0)   begin errors++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0)   begin errors++; $display("FAIL mthi_done got %b want 0", bus.done); end
    bus.mdu_op = MFLO; #1;
    checks++;
    if (bus.mdu_out !== 32'h8000_0000) begin errors++; $display("FAIL mflo_out got %h want 80000000", bus.mdu_out); end
    bus.mdu_op = MFHI; #1;
    checks += 2;
    if (bus.mdu_out !== 32'h1234) begin errors++; $display("FAIL mfhi_out got %h want 1234", bus.mdu_out); end
    if (bus.stall !== 1'b0)       begin errors++; $display("FAIL mfhi_stall got %b want 0", bus.stall); end
    bus.mdu_op = MDU_NOP; #1;
    checks++;
    if (bus.mdu_out !== 32'h0) begin errors++; $display("FAIL nop_out got %h want 0", bus.mdu_out); end
    step();
    issue(MTLO, 32'h55, 32'h0);
    checks++;
    if (bus.lo !== 32'h55) begin errors++; $display("FAIL mtlo_lo got %h want 55", bus.lo); end
    issue(DIV, 32'd9, 32'd0);
    wait_busy(n);
    checks += 4;
    if (n != 10)             begin errors++; $display("FAIL div0_busy_cycles got %0d want 10", n); end
    if (bus.done !== 1'b1)   begin errors++; $display("FAIL div0_done got %b want 1", bus.done); end
    if (bus.hi !== 32'h1234) begin errors++; $display("FAIL div0_hi got %h want 1234", bus.hi); end
    if (bus.lo !== 32'h55)   begin errors++; $display("FAIL div0_lo got %h want 55", bus.lo); end
  endtask

  task automatic test_accumulate();
    int n;
    issue(MTHI, 32'h0, 32'h0);
    issue(MTLO, 32'hFFFF_FFFF, 32'h0);
    issue(MADD, 32'd2, 32'd3);
    wait_busy(n);
    checks += 3;
    if (n != 5)           begin errors++; $display("FAIL madd_busy_cycles got %0d want 5", n); end
    if (bus.hi !== 32'd1) begin errors++; $display("FAIL madd_hi got %h want 1", bus.hi); end
    if (bus.lo !== 32'd5) begin errors++; $display("FAIL madd_lo got %h want 5", bus.lo); end
    issue(MTHI, 32'h0, 32'h0);
    issue(MTLO, 32'h0, 32'h0);
    issue(MSUBU, 32'd1, 32'd1);
    wait_busy(n);
    checks += 2;
    if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msubu_hi got %h want ffffffff", bus.hi); end
    if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msubu_lo got %h want ffffffff", bus.lo); end
    issue(MSUB, 32'hFFFF_FFFF, 32'd1);
    wait_busy(n);
    checks += 2;
    if (bus.hi !== 32'h0) begin errors++; $display("FAIL msub_hi got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL msub_lo got %h want 0", bus.lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    int stall_bad = 0;
    issue(DIVU, 32'd100, 32'd7);
    for (int i = 0; i < 5; i++) begin
      bus.start = 1'b1; bus.mdu_op = MULT; bus.src_a = 32'd5; bus.src_b = 32'd5;
      #1;
      if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stall_bad++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.mdu_op = MDU_NOP;
    wait_busy(n);
    checks += 4;
    if (stall_bad != 0)    begin errors++; $display("FAIL b2b_stall bad_cycles %0d want 0", stall_bad); end
    if (n + 5 != 10)       begin errors++; $display("FAIL b2b_busy_cycles got %0d want 10", n + 5); end
    if (bus.hi !== 32'd2)  begin errors++; $display("FAIL b2b_hi got %h want 2", bus.hi); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL b2b_lo got %h want 0e", bus.lo); end
    repeat (3) step();
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_no_queue_busy got %b want 0", bus.busy); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL b2b_no_queue_lo got %h want 0e", bus.lo); end
  endtask

  task automatic test_cancel();
    issue(DIV, 32'd50, 32'd3);
    step();
    step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    checks += 4;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL cancel_done got %b want 0", bus.done); end
    if (bus.hi !== 32'd2)  begin errors++; $display("FAIL cancel_hi got %h want 2", bus.hi); end
    if (bus.lo !== 32'd14) begin errors++; $display("FAIL cancel_lo got %h want 0e", bus.lo); end
    step();
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL cancel_done_late got %b want 0", bus.done); end
    bus.start = 1'b1; bus.mdu_op = MTHI; bus.src_a = 32'hDEAD; bus.cancel = 1'b1;
    step();
    bus.mdu_op = DIV; bus.src_a = 32'd8; bus.src_b = 32'd2;
    #1;
    checks += 2;
    if (bus.hi !== 32'd2)   begin errors++; $display("FAIL cancel_mthi_hi got %h want 2", bus.hi); end
    if (bus.stall !== 1'b0) begin errors++; $display("FAIL cancel_div_stall got %b want 0", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.mdu_op = MDU_NOP;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL cancel_div_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_op();
    int done_seen = 0;
    issue(MTHI, 32'h77, 32'h0);
    issue(MULT, 32'd3, 32'd3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
    if (bus.hi !== 32'h0)  begin errors++; $display("FAIL rst_mid_hi got %h want 0", bus.hi); end
    if (bus.lo !== 32'h0)  begin errors++; $display("FAIL rst_mid_lo got %h want 0", bus.lo); end
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) done_seen++;
      step();
    end
    checks += 2;
    if (done_seen != 0)   begin errors++; $display("FAIL rst_mid_done got %0d pulses want 0", done_seen); end
    if (bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo_late got %h want 0", bus.lo); end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.mdu_op = MDU_NOP; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_move_and_div0();
    test_accumulate();
    test_back_to_back();
    test_cancel();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
